lz77_decoder: RTL and testbench

Decodes the LZ77 token stream (offset, match_len, char_nxt) produced by the team's LZ77 encoder back into the original 8-bit character stream. Output rate is one character per clock.
- Keeps a 9-entry search buffer of the most recently emitted characters and copies matched runs from it, then emits the literal next character.
- Sits at the decompression end of the HW3 LZ77 path.
- Stops permanently after emitting the terminator character '$' (8'h24).

---
 rtl/lz77_pkg.sv | 25 ++
 rtl/lz77_search_buf.sv | 48 ++++
 rtl/lz77_decoder.sv | 168 ++++++++++++++++
 tb/tb_lz77_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions: geometry of the search buffer, token layout and
// decoder state encoding. Used by both the encoder and the decoder.
package lz77_pkg;

    localparam int SEARCH_DEPTH = 9;
    localparam int OFFSET_W     = 4;
    localparam int LEN_W        = 3;
    localparam int FILL_W       = $clog2(SEARCH_DEPTH + 1);

    localparam logic [7:0] TERM_CHAR = 8'h24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [OFFSET_W-1:0] offset;
        logic [LEN_W-1:0]    match_len;
        logic [7:0]          chr;
    } token_t;

endpackage

// File: rtl/lz77_search_buf.sv
// Search buffer of the most recently emitted characters. Entry 0 is the
// newest; a shift pushes a new character in at 0 and drops the oldest.
// Out-of-range read indices clamp to the oldest entry.
import lz77_pkg::*;

module lz77_search_buf (
    input  logic                clk,
    input  logic                reset,
    input  logic                shift_en,
    input  logic [7:0]          shift_din,
    input  logic [OFFSET_W-1:0] rd_idx,
    output logic [7:0]          rd_data
);

    localparam logic [OFFSET_W-1:0] LAST_IDX = OFFSET_W'(SEARCH_DEPTH - 1);

    logic [7:0] sb_q [SEARCH_DEPTH];
    logic [7:0] sb_d [SEARCH_DEPTH];

    // Next buffer contents: hold, or shift everything one place older.
    always_comb begin
        for (int i = 0; i < SEARCH_DEPTH; i++) begin
            sb_d[i] = sb_q[i];
        end
        if (shift_en) begin
            sb_d[0] = shift_din;
            for (int i = 1; i < SEARCH_DEPTH; i++) begin
                sb_d[i] = sb_q[i-1];
            end
        end
    end

    // Buffer storage; cleared to zero so unfilled entries read as 8'h00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                sb_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign rd_data = (rd_idx > LAST_IDX) ? sb_q[SEARCH_DEPTH-1] : sb_q[rd_idx];

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands (offset, match_len, char) tokens into a
// character stream at one character per clock, stopping for good after '$'.
// Optional offset checking with a sticky err output: define LZ77_DEC_CHECK_EN.
import lz77_pkg::*;

module lz77_decoder (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [LEN_W-1:0]    match_len,
    input  logic [7:0]          char_in,
    output logic                out_valid,
    output logic [7:0]          char_out,
`ifdef LZ77_DEC_CHECK_EN
    output logic                err,
`endif
    output logic                finish
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [7:0]          chr_q, chr_d;
    logic [7:0]          char_out_q, char_out_d;
    logic                out_valid_q, out_valid_d;
    logic                finish_q, finish_d;

    logic                sb_shift;
    logic [7:0]          sb_rd;
    logic                accept;
    token_t              tok_in;

    assign tok_in   = '{offset: offset, match_len: match_len, chr: char_in};
    assign in_ready = (state_q == IDLE) || ((state_q == LIT) && (chr_q != TERM_CHAR));
    assign accept   = in_valid && in_ready;

    lz77_search_buf u_sb (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (sb_shift),
        .shift_din (char_out_d),
        .rd_idx    (off_q),
        .rd_data   (sb_rd)
    );

    // Decoder FSM next state: latch tokens, run the copy, then the literal.
    // The copy index stays fixed while the buffer shifts, which is what makes
    // overlapping copies replicate the recent characters.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        chr_d       = chr_q;
        char_out_d  = char_out_q;
        out_valid_d = 1'b0;
        finish_d    = finish_q;
        sb_shift    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d   = tok_in.offset;
                    cnt_d   = tok_in.match_len;
                    chr_d   = tok_in.chr;
                    state_d = (tok_in.match_len != '0) ? COPY : LIT;
                end
            end
            COPY: begin
                char_out_d  = sb_rd;
                out_valid_d = 1'b1;
                sb_shift    = 1'b1;
                cnt_d       = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = LIT;
                end
            end
            LIT: begin
                char_out_d  = chr_q;
                out_valid_d = 1'b1;
                sb_shift    = 1'b1;
                if (chr_q == TERM_CHAR) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end else if (accept) begin
                    off_d   = tok_in.offset;
                    cnt_d   = tok_in.match_len;
                    chr_d   = tok_in.chr;
                    state_d = (tok_in.match_len != '0) ? COPY : LIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            chr_q       <= 8'h00;
            char_out_q  <= 8'h00;
            out_valid_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            chr_q       <= chr_d;
            char_out_q  <= char_out_d;
            out_valid_q <= out_valid_d;
            finish_q    <= finish_d;
        end
    end

    assign out_valid = out_valid_q;
    assign char_out  = char_out_q;
    assign finish    = finish_q;

`ifdef LZ77_DEC_CHECK_EN
    localparam logic [OFFSET_W-1:0] LAST_IDX = OFFSET_W'(SEARCH_DEPTH - 1);

    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                err_q, err_d;
    logic [OFFSET_W:0]   need_cnt;

    // The fill count includes a character emitted on the same edge as the
    // acceptance, since that character is in the buffer before the copy reads.
    assign need_cnt = {1'b0, offset} + (OFFSET_W+1)'(1);

    // Fill tracking and sticky error flag for offsets that reach past history.
    always_comb begin
        fill_d = fill_q;
        if (sb_shift && (fill_q != FILL_W'(SEARCH_DEPTH))) begin
            fill_d = fill_q + FILL_W'(1);
        end
        err_d = err_q;
        if (accept) begin
            if (offset > LAST_IDX) begin
                err_d = 1'b1;
            end
            if ((match_len != '0) && (need_cnt > (OFFSET_W+1)'(fill_d))) begin
                err_d = 1'b1;
            end
        end
    end

    // Checker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed testbench for lz77_decoder. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, away from the edge.
`timescale 1ns/1ps
module tb_lz77_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_in;
    logic       out_valid;
    logic [7:0] char_out;
    logic       finish;
`ifdef LZ77_DEC_CHECK_EN
    logic       err;
`endif

    int total = 0;
    int bad   = 0;

    lz77_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .offset    (offset),
        .match_len (match_len),
        .char_in   (char_in),
        .out_valid (out_valid),
        .char_out  (char_out),
`ifdef LZ77_DEC_CHECK_EN
        .err       (err),
`endif
        .finish    (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] c);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_char"}, {24'd0, char_out}, {24'd0, c});
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
        in_valid  = v;
        offset    = o;
        match_len = l;
        char_in   = c;
        if (v) $display("token off=%0d len=%0d char=%02h", o, l, c);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 3'd0, 8'h00);
    endtask

    initial begin
        logic [7:0] ch;
        reset = 1'b1;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_char_out", {24'd0, char_out}, 32'h00);
        check("rst_finish", {31'd0, finish}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef LZ77_DEC_CHECK_EN
        check("rst_err", {31'd0, err}, 32'd0);
`endif
        reset = 1'b0;

        // Literal-only stream ending in '$'
        drive(1'b1, 4'd0, 3'd0, "a");
        tick();
        check("t1_latency", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 4'd0, 3'd0, "b");
        tick();
        chk_out("t1_a", "a");
        drive(1'b1, 4'd0, 3'd0, "$");
        tick();
        chk_out("t1_b", "b");
        check("t1_finish_early", {31'd0, finish}, 32'd0);
        idle();
        tick();
        chk_out("t1_term", 8'h24);
        check("t1_finish", {31'd0, finish}, 32'd1);
        check("t1_ready_done", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 4'd0, 3'd0, "k");
        tick();
        check("t1_done_valid", {31'd0, out_valid}, 32'd0);
        check("t1_done_finish", {31'd0, finish}, 32'd1);
        tick();
        check("t1_done_ignored", {31'd0, out_valid}, 32'd0);
        idle();

        // Asynchronous reset clears finish without a clock edge
        reset = 1'b1;
        #1;
        check("rst_async_finish", {31'd0, finish}, 32'd0);
        tick();
        reset = 1'b0;

        // Overlapping copy: x then (0,5,y)
        drive(1'b1, 4'd0, 3'd0, "x");
        tick();
        drive(1'b1, 4'd0, 3'd5, "y");
        tick();
        chk_out("t2_x0", "x");
        idle();
        for (int i = 0; i < 5; i++) begin
            check("t2_ready_copy", {31'd0, in_ready}, 32'd0);
            tick();
            chk_out("t2_xcopy", "x");
        end
        tick();
        chk_out("t2_y", "y");
        tick();
        check("t2_after", {31'd0, out_valid}, 32'd0);
`ifdef LZ77_DEC_CHECK_EN
        check("t2_err_legal", {31'd0, err}, 32'd0);
`endif

        // Max distance: "123456789" then (8,3,'Z') -> 1,2,3,Z
        drive(1'b1, 4'd0, 3'd0, "1");
        tick();
        for (int i = 1; i < 9; i++) begin
            ch = 8'h31 + 8'(i);
            drive(1'b1, 4'd0, 3'd0, ch);
            tick();
            chk_out("t3_lit", ch - 8'd1);
        end
        drive(1'b1, 4'd8, 3'd3, "Z");
        tick();
        chk_out("t3_lit9", "9");
        idle();
        tick();
        chk_out("t3_c1", "1");
        tick();
        chk_out("t3_c2", "2");
        tick();
        chk_out("t3_c3", "3");
        tick();
        chk_out("t3_Z", "Z");

        // Token gap: buffer survives idle cycles
        drive(1'b1, 4'd0, 3'd0, "g");
        tick();
        idle();
        tick();
        chk_out("t4_g", "g");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_gap", {31'd0, out_valid}, 32'd0);
        end
        drive(1'b1, 4'd1, 3'd2, "h");
        tick();
        idle();
        check("t4_accept_cycle", {31'd0, out_valid}, 32'd0);
        tick();
        chk_out("t4_c1", "Z");
        tick();
        chk_out("t4_c2", "g");
        tick();
        chk_out("t4_h", "h");
        tick();
        check("t4_after", {31'd0, out_valid}, 32'd0);
`ifdef LZ77_DEC_CHECK_EN
        check("t4_err_legal", {31'd0, err}, 32'd0);
`endif

        // Reset during the 3rd cycle of a length-7 copy
        drive(1'b1, 4'd0, 3'd0, "m");
        tick();
        drive(1'b1, 4'd0, 3'd7, "n");
        tick();
        chk_out("t5_m", "m");
        idle();
        tick();
        chk_out("t5_c1", "m");
        tick();
        chk_out("t5_c2", "m");
        reset = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_finish", {31'd0, finish}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("t5_no_partial", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 4'd0, 3'd0, "q");
        tick();
        idle();
        check("t5_q_latency", {31'd0, out_valid}, 32'd0);
        tick();
        chk_out("t5_q", "q");
        tick();
        check("t5_q_only", {31'd0, out_valid}, 32'd0);
        // sb[1] must have been cleared by reset, not still hold 'm'
        drive(1'b1, 4'd1, 3'd1, "s");
        tick();
        idle();
        tick();
        chk_out("t5_cleared", 8'h00);
        tick();
        chk_out("t5_s", "s");
        tick();

`ifdef LZ77_DEC_CHECK_EN
        // Copy reaching past history right after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_err_clear", {31'd0, err}, 32'd0);
        drive(1'b1, 4'd4, 3'd2, "a");
        tick();
        idle();
        check("t6_err_fill", {31'd0, err}, 32'd1);
        tick();
        tick();
        tick();
        tick();
        // Offset beyond the buffer depth
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 4'd9, 3'd0, "w");
        tick();
        idle();
        check("t6_err_off9", {31'd0, err}, 32'd1);
        tick();
        chk_out("t6_w", "w");
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
